lcd_bus_reader: RTL and testbench
=================================

# lcd_bus_reader

Read-side companion to the LCD write controller. It runs HD44780-style read cycles on the shared LCD bus: a busy-flag/address-counter read (RS=0) or a DDRAM/CGRAM data read (RS=1). It drives RW/RS/E with programmable setup, enable-high and enable-low timing, then samples the bus and returns the byte with a one-cycle valid strobe. It sits beside the write controller under the LCD top level, and its `busLock` output holds the write path off while a read is in flight.

## Interface
- `SETUP_CYCLES`, default 3: cycles with RW/RS valid and E low before E rises (tAS); range 1..255.
- `EN_HIGH_CYCLES`, default 12: E-high width in cycles; range 1..255.
- `EN_LOW_CYCLES`, default 12: E-low hold after E falls, before the next access; range 1..255.
- `BUSY_POLL_LIMIT`, default 255: maximum busy reads per data request (used only with `LCD_BUSY_POLL_EN`); range 1..255.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rdReq` in 1: level request, sampled only in IDLE.
- `rdSel` in 1: 0 = busy/address read, 1 = data read; latched at accept.
- `lcdBusIn` in 8: LCD data pins as seen through the top-level pad.
- `lcdReadWriteSel` out 1: 1 = read; 0 whenever idle, so the write path owns the bus.
- `lcdRsSelect` out 1: 0 = command/busy, 1 = data.
- `lcdEnableOut` out 1: LCD E strobe.
- `busLock` out 1: 1 while a read cycle owns the bus.
- `rdData` out 8: last byte read.
- `busyFlag` out 1: bit 7 of the last busy read.
- `addrCounter` out 7: bits 6:0 of the last busy read.
- `rdValid` out 1: one-cycle strobe marking that outputs were updated.
- `timeoutErr` out 1: sticky flag, busy-poll limit exceeded.

## Operation
- Reset values: all outputs 0, state IDLE, counters 0. Reset asserted mid-cycle drops E, RW, RS and `busLock` immediately (asynchronously) and abandons the cycle with no `rdValid`.
- IDLE: if `rdReq`=1, latch `rdSel`, go to SETUP, load counter. Otherwise stay.
- SETUP: RW=1, RS=latched sel, E=0, `busLock`=1 for `SETUP_CYCLES` cycles, then EN_HIGH.
- EN_HIGH: E=1 for `EN_HIGH_CYCLES`. `lcdBusIn` is captured into an internal register at the edge ending the last EN_HIGH cycle, before E falls. Then EN_LOW.
- EN_LOW: E=0, RW/RS held for `EN_LOW_CYCLES`, then DONE.
- DONE is a single cycle shared with the return to IDLE:
  - `rdValid`=1 and RW=0, `busLock`=0.
  - `rdData` takes the captured byte.
  - For sel=0 reads, `busyFlag`/`addrCounter` also update. For sel=1 reads they keep their old values.
- `rdReq` is ignored outside IDLE, with no queueing. If `rdReq` is still high in the `rdValid` cycle, the next read is accepted at that cycle's edge, giving back-to-back reads.
- Counter is 8-bit, counts down to 1. The parameter value 0 is illegal.

## Timing
- Request sampled at edge N (IDLE): SETUP occupies cycles N+1..N+S, EN_HIGH N+S+1..N+S+H, EN_LOW N+S+H+1..N+S+H+L.
- `rdValid` is high in cycle N+1+S+H+L. With defaults that is N+28.
- `busLock` is high in cycles N+1..N+S+H+L.
- `rdData` is stable from the `rdValid` cycle until the next `rdValid` or reset.

## Configuration
- `LCD_BUSY_POLL_EN` defined:
  - A sel=1 request first runs busy reads (full SETUP/EN_HIGH/EN_LOW each, RS=0).
  - Each busy read updates `busyFlag`/`addrCounter` without `rdValid`.
  - It repeats while bit 7=1, up to `BUSY_POLL_LIMIT` reads, then performs the data read.
  - If bit 7 is still 1 after the limit: `timeoutErr`←1 (sticky until reset), `rdValid` pulses, `rdData` is unchanged, and no data read is issued.
- Not defined: data reads issue immediately, `timeoutErr` is tied 0, and `BUSY_POLL_LIMIT` is unused.

## Test plan
- Reset, then idle 10 cycles -> all outputs 0 and E never rises.
- `rdReq`=1 at edge N with `rdSel`=0 and bus=8'h85 -> RW=1 N+1..N+27, E=1 N+4..N+15, `rdValid` at N+28, `rdData`=8'h85, `busyFlag`=1, `addrCounter`=7'h05.
- `rdSel`=1, bus=8'h31, `rdReq` held high for 2 reads -> two `rdValid` strobes 28 cycles apart, `rdData`=8'h31, `busyFlag`/`addrCounter` unchanged.
- Assert `rst` low during EN_HIGH -> E/RW/`busLock` 0 in the same cycle, no `rdValid`; after release a new read completes normally.
- With `LCD_BUSY_POLL_EN`: bus=8'h80 for 3 busy reads, then 8'h07 busy, then 8'h41 data -> 4 busy reads, then a data read, one `rdValid`, `rdData`=8'h41, `timeoutErr`=0.
- With `LCD_BUSY_POLL_EN`, `BUSY_POLL_LIMIT`=2, bus stuck 8'hFF -> 2 busy reads, `rdValid` with `timeoutErr`=1, no RS=1 cycle.

Source files
------------

// File: rtl/lcd_bus_reader.sv
// lcd_bus_reader: HD44780-style read cycles (busy/address or data) on the shared LCD bus.
// Define LCD_BUSY_POLL_EN to make data reads first poll the busy flag.
module lcd_bus_reader #(
    parameter int SETUP_CYCLES    = 3,
    parameter int EN_HIGH_CYCLES  = 12,
    parameter int EN_LOW_CYCLES   = 12,
    parameter int BUSY_POLL_LIMIT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdReq,
    input  logic       rdSel,
    input  logic [7:0] lcdBusIn,
    output logic       lcdReadWriteSel,
    output logic       lcdRsSelect,
    output logic       lcdEnableOut,
    output logic       busLock,
    output logic [7:0] rdData,
    output logic       busyFlag,
    output logic [6:0] addrCounter,
    output logic       rdValid,
    output logic       timeoutErr
);
`ifdef LCD_BUSY_POLL_EN
    localparam bit POLL_EN = 1'b1;
`else
    localparam bit POLL_EN = 1'b0;
`endif
    localparam logic [7:0] S_LOAD = 8'(SETUP_CYCLES);
    localparam logic [7:0] H_LOAD = 8'(EN_HIGH_CYCLES);
    localparam logic [7:0] L_LOAD = 8'(EN_LOW_CYCLES);
    localparam logic [7:0] P_LAST = 8'(BUSY_POLL_LIMIT - 1);

    typedef enum logic [2:0] {IDLE, SETUP, EN_HIGH, EN_LOW, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cap_q, cap_d;
    logic [7:0] data_q, data_d;
    logic [7:0] polls_q, polls_d;
    logic [6:0] addr_q, addr_d;
    logic       sel_q, sel_d;
    logic       poll_q, poll_d;
    logic       busy_q, busy_d;
    logic       tmo_q, tmo_d;
    logic       last;

    assign last = cnt_q == 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            data_q  <= '0;
            polls_q <= '0;
            addr_q  <= '0;
            sel_q   <= 1'b0;
            poll_q  <= 1'b0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            data_q  <= data_d;
            polls_q <= polls_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            poll_q  <= poll_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        data_d  = data_q;
        polls_d = polls_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        poll_d  = poll_q;
        busy_d  = busy_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = rdReq ? SETUP : IDLE;
                if (rdReq) begin
                    cnt_d   = S_LOAD;
                    sel_d   = rdSel;
                    poll_d  = POLL_EN & rdSel;
                    polls_d = '0;
                end
            end
            SETUP: begin
                state_d = last ? EN_HIGH : SETUP;
                cnt_d   = last ? H_LOAD : cnt_q - 8'd1;
            end
            EN_HIGH: begin
                state_d = last ? EN_LOW : EN_HIGH;
                cnt_d   = last ? L_LOAD : cnt_q - 8'd1;
                if (last)
                    cap_d = lcdBusIn;
            end
            EN_LOW: begin
                cnt_d = cnt_q - 8'd1;
                if (last) begin
                    if (!sel_q || poll_q) begin
                        busy_d = cap_q[7];
                        addr_d = cap_q[6:0];
                    end
                    // A busy poll chains straight into the next access without a DONE cycle.
                    if (poll_q) begin
                        polls_d = polls_q + 8'd1;
                        state_d = SETUP;
                        cnt_d   = S_LOAD;
                        if (!cap_q[7]) begin
                            poll_d = 1'b0;
                        end else if (polls_q == P_LAST) begin
                            tmo_d   = 1'b1;
                            poll_d  = 1'b0;
                            state_d = DONE;
                        end
                    end else begin
                        data_d  = cap_q;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busLock         = state_q == SETUP || state_q == EN_HIGH || state_q == EN_LOW;
        lcdReadWriteSel = busLock;
        lcdRsSelect     = busLock & sel_q & ~poll_q;
        lcdEnableOut    = state_q == EN_HIGH;
        rdValid         = state_q == DONE;
        rdData          = data_q;
        busyFlag        = busy_q;
        addrCounter     = addr_q;
        timeoutErr      = tmo_q;
    end
endmodule

// File: tb/tb_lcd_bus_reader.sv
// tb_lcd_bus_reader: randomized self-checking bench for lcd_bus_reader against a transaction-level model.
module tb_lcd_bus_reader;
    localparam int S = 3, H = 12, L = 12, LIM = 4;
    localparam int P = S + H + L;
`ifdef LCD_BUSY_POLL_EN
    localparam bit POLL = 1'b1;
`else
    localparam bit POLL = 1'b0;
`endif

    logic       clk = 1'b0, rst, rdReq, rdSel;
    logic [7:0] lcdBusIn;
    logic       lcdReadWriteSel, lcdRsSelect, lcdEnableOut, busLock, rdValid, timeoutErr, busyFlag;
    logic [7:0] rdData;
    logic [6:0] addrCounter;

    int n_checks = 0, n_pass = 0, cyc = 0, v_cyc = 0;
    logic [7:0] bus_seq[$];
    logic [7:0] exp_data = 0;
    logic       exp_busy = 0, exp_tmo = 0;
    logic [6:0] exp_addr = 0;

    lcd_bus_reader #(.SETUP_CYCLES(S), .EN_HIGH_CYCLES(H), .EN_LOW_CYCLES(L), .BUSY_POLL_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .rdReq(rdReq), .rdSel(rdSel), .lcdBusIn(lcdBusIn),
        .lcdReadWriteSel(lcdReadWriteSel), .lcdRsSelect(lcdRsSelect), .lcdEnableOut(lcdEnableOut),
        .busLock(busLock), .rdData(rdData), .busyFlag(busyFlag), .addrCounter(addrCounter),
        .rdValid(rdValid), .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Issues one request made of nreads bus accesses (busy polls then the final one) and checks
    // {RW,RS,E,busLock,rdValid} every cycle; ends at the negedge of the rdValid cycle.
    task automatic run_req(input bit sel, input bit hold, input int nreads, input bit last_rs);
        logic [4:0] exp_v, got_v;
        rdReq = 1'b1;
        rdSel = sel;
        lcdBusIn = bus_seq[0];
        @(posedge clk);
        for (int j = 0; j < nreads; j++) begin
            for (int k = 1; k <= P; k++) begin
                @(negedge clk);
                exp_v = {1'b1, (j == nreads - 1) ? last_rs : 1'b0, k > S && k <= S + H, 1'b1, 1'b0};
                got_v = {lcdReadWriteSel, lcdRsSelect, lcdEnableOut, busLock, rdValid};
                n_checks++;
                if (got_v !== exp_v)
                    $display("FAIL wave read%0d cyc%0d: got %b want %b", j, k, got_v, exp_v);
                else
                    n_pass++;
                if (k == 1) begin
                    rdReq = hold;
                    lcdBusIn = bus_seq[j];
                end
            end
        end
        @(negedge clk);
        got_v = {lcdReadWriteSel, lcdRsSelect, lcdEnableOut, busLock, rdValid};
        n_checks++;
        if (got_v !== 5'b00001)
            $display("FAIL wave done: got %b want 00001", got_v);
        else
            n_pass++;
        v_cyc = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b0; rdReq = 1'b0; rdSel = 1'b0; lcdBusIn = 8'h00;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({lcdReadWriteSel, lcdRsSelect, lcdEnableOut, busLock, rdValid, timeoutErr, busyFlag, addrCounter, rdData} !== '0)
            $display("FAIL reset_outputs: got %h %h want all zero", {lcdReadWriteSel, lcdRsSelect, lcdEnableOut, busLock, rdValid, timeoutErr, busyFlag}, {addrCounter, rdData});
        else
            n_pass++;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({lcdReadWriteSel, lcdEnableOut, busLock, rdValid, rdData} !== '0)
                $display("FAIL idle cyc%0d: got rw=%b e=%b lock=%b v=%b d=%h want 0", i, lcdReadWriteSel, lcdEnableOut, busLock, rdValid, rdData);
            else
                n_pass++;
        end
    endtask

    task automatic test_busy_read();
        bus_seq = {8'h85};
        run_req(1'b0, 1'b0, 1, 1'b0);
        exp_data = 8'h85; exp_busy = 1'b1; exp_addr = 7'h05;
        n_checks++;
        if ({rdData, busyFlag, addrCounter, timeoutErr} !== {8'h85, 1'b1, 7'h05, 1'b0})
            $display("FAIL busy_read: got d=%h b=%b a=%h t=%b want d=85 b=1 a=05 t=0", rdData, busyFlag, addrCounter, timeoutErr);
        else
            n_pass++;
        @(negedge clk);
        n_checks++;
        if (rdValid !== 1'b0)
            $display("FAIL valid_one_cycle: got %b want 0", rdValid);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        bit sel;
        int first;
        sel = !POLL;
        bus_seq = {8'h31, 8'h31};
        run_req(sel, 1'b1, 1, sel);
        first = v_cyc;
        exp_data = 8'h31;
        if (!sel) begin exp_busy = 1'b0; exp_addr = 7'h31; end
        n_checks++;
        if (rdData !== exp_data)
            $display("FAIL b2b_first_data: got %h want %h", rdData, exp_data);
        else
            n_pass++;
        run_req(sel, 1'b0, 1, sel);
        n_checks++;
        if (v_cyc - first !== 28)
            $display("FAIL b2b_spacing: got %0d want 28", v_cyc - first);
        else
            n_pass++;
        n_checks++;
        if ({rdData, busyFlag, addrCounter} !== {exp_data, exp_busy, exp_addr})
            $display("FAIL b2b_values: got d=%h b=%b a=%h want d=%h b=%b a=%h", rdData, busyFlag, addrCounter, exp_data, exp_busy, exp_addr);
        else
            n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit sel;
        logic [7:0] bus;
        int nr;
        for (int t = 0; t < 8; t++) begin
            sel = 1'($urandom);
            bus = 8'($urandom);
            if (POLL && sel) bus[7] = 1'b0;
            nr = (POLL && sel) ? 2 : 1;
            bus_seq = {bus, bus};
            run_req(sel, 1'b0, nr, sel);
            exp_data = bus;
            if (!sel || POLL) begin exp_busy = bus[7]; exp_addr = bus[6:0]; end
            n_checks++;
            if ({rdData, busyFlag, addrCounter, timeoutErr} !== {exp_data, exp_busy, exp_addr, exp_tmo})
                $display("FAIL random%0d sel=%b: got d=%h b=%b a=%h t=%b want d=%h b=%b a=%h t=%b", t, sel,
                         rdData, busyFlag, addrCounter, timeoutErr, exp_data, exp_busy, exp_addr, exp_tmo);
            else
                n_pass++;
            @(negedge clk);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        rdReq = 1'b1; rdSel = 1'b0; lcdBusIn = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        rdReq = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (lcdEnableOut !== 1'b1)
            $display("FAIL mid_en_high: got %b want 1", lcdEnableOut);
        else
            n_pass++;
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({lcdReadWriteSel, lcdRsSelect, lcdEnableOut, busLock, rdValid, rdData} !== '0)
            $display("FAIL mid_reset_async: got rw=%b rs=%b e=%b lock=%b v=%b d=%h want 0", lcdReadWriteSel, lcdRsSelect, lcdEnableOut, busLock, rdValid, rdData);
        else
            n_pass++;
        exp_data = 0; exp_busy = 0; exp_addr = 0; exp_tmo = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n_checks++;
            if ({rdValid, lcdEnableOut, busLock} !== 3'b000)
                $display("FAIL post_reset_quiet cyc%0d: got v=%b e=%b lock=%b want 0", i, rdValid, lcdEnableOut, busLock);
            else
                n_pass++;
        end
        bus_seq = {8'h2C};
        run_req(1'b0, 1'b0, 1, 1'b0);
        n_checks++;
        if ({rdData, busyFlag, addrCounter} !== {8'h2C, 1'b0, 7'h2C})
            $display("FAIL post_reset_read: got d=%h b=%b a=%h want d=2c b=0 a=2c", rdData, busyFlag, addrCounter);
        else
            n_pass++;
        exp_data = 8'h2C; exp_busy = 1'b0; exp_addr = 7'h2C;
        @(negedge clk);
    endtask

`ifdef LCD_BUSY_POLL_EN
    task automatic test_poll_ok();
        bus_seq = {8'h80, 8'h80, 8'h80, 8'h07, 8'h41};
        run_req(1'b1, 1'b0, 5, 1'b1);
        exp_data = 8'h41; exp_busy = 1'b0; exp_addr = 7'h07;
        n_checks++;
        if ({rdData, busyFlag, addrCounter, timeoutErr} !== {8'h41, 1'b0, 7'h07, 1'b0})
            $display("FAIL poll_ok: got d=%h b=%b a=%h t=%b want d=41 b=0 a=07 t=0", rdData, busyFlag, addrCounter, timeoutErr);
        else
            n_pass++;
        @(negedge clk);
    endtask

    task automatic test_poll_timeout();
        bus_seq = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_req(1'b1, 1'b0, LIM, 1'b0);
        exp_busy = 1'b1; exp_addr = 7'h7F; exp_tmo = 1'b1;
        n_checks++;
        if ({rdData, busyFlag, addrCounter, timeoutErr} !== {exp_data, 1'b1, 7'h7F, 1'b1})
            $display("FAIL poll_timeout: got d=%h b=%b a=%h t=%b want d=%h b=1 a=7f t=1", rdData, busyFlag, addrCounter, timeoutErr, exp_data);
        else
            n_pass++;
        @(negedge clk);
        bus_seq = {8'h12};
        run_req(1'b0, 1'b0, 1, 1'b0);
        exp_data = 8'h12; exp_busy = 1'b0; exp_addr = 7'h12;
        n_checks++;
        if ({rdData, timeoutErr} !== {8'h12, 1'b1})
            $display("FAIL timeout_sticky: got d=%h t=%b want d=12 t=1", rdData, timeoutErr);
        else
            n_pass++;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_busy_read();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef LCD_BUSY_POLL_EN
        test_poll_ok();
        test_poll_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
